// File: rtl/matrix_seq_pkg.sv
// Shared constants and state encoding for the matrix element sequencers.
package matrix_seq_pkg;

    localparam int unsigned DIM    = 4;
    localparam int unsigned N_ELEM = DIM * DIM;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/matrix_sel_map.sv
// Scan position to mux select: row-major by default, column-major when transposed.
module matrix_sel_map
    import matrix_seq_pkg::*;
(
    input  logic [SEL_W-1:0] i_cnt,
    input  logic             i_transpose,
    output logic [SEL_W-1:0] o_sel_c
);

    // sel[1:0] is the row and sel[3:2] the column, so row-major swaps the counter halves
    always_comb begin
        o_sel_c = {i_cnt[1:0], i_cnt[3:2]};
        if (i_transpose) begin
            o_sel_c = i_cnt;
        end
    end

endmodule

// File: rtl/matrix_element_sequencer.sv
// Walks the 4x4 element mux and streams the 16 selected bytes over valid/ready.
// Optional TRANSPOSE_EN adds a transpose input selecting column-major order.
module matrix_element_sequencer
    import matrix_seq_pkg::*;
#(
    parameter int unsigned ELEM_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
`ifdef TRANSPOSE_EN
    input  logic              transpose,
`endif
    output logic [SEL_W-1:0]  sel,
    input  logic [ELEM_W-1:0] elem_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_e            r_state;
    logic [SEL_W-1:0]  r_cnt;
    logic [SEL_W-1:0]  r_sel;
    logic              r_valid;
    logic [ELEM_W-1:0] r_data;
    logic [SEL_W-1:0]  r_idx;
    logic              r_last;
    logic              r_busy;
    logic              r_done;

    state_e            w_state_nxt;
    logic [SEL_W-1:0]  w_cnt_nxt;
    logic              w_valid_nxt;
    logic [ELEM_W-1:0] w_data_nxt;
    logic [SEL_W-1:0]  w_idx_nxt;
    logic              w_last_nxt;
    logic              w_done_nxt;
    logic              w_load;
    logic              w_tr_cur;
    logic              w_tr_nxt;
    logic [SEL_W-1:0]  w_sel_map;

`ifdef TRANSPOSE_EN
    logic r_transpose;
    assign w_tr_cur = r_transpose;
`else
    assign w_tr_cur = 1'b0;
`endif

    assign w_load = !r_valid || out_ready;

    // Next-state and datapath decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tr_nxt    = w_tr_cur;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_done_nxt  = 1'b0;
        if (abort) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
`ifdef TRANSPOSE_EN
                        w_tr_nxt    = transpose;
`endif
                    end
                end
                RUN: begin
                    if (w_load) begin
                        w_data_nxt  = elem_in;
                        w_idx_nxt   = r_cnt;
                        w_last_nxt  = (r_cnt == SEL_W'(N_ELEM - 1));
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = r_cnt + SEL_W'(1);
                        if (r_cnt == SEL_W'(N_ELEM - 1)) begin
                            w_state_nxt = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (r_valid && out_ready) begin
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Select is computed from the next counter so the mux sees it straight from flops
    matrix_sel_map u_sel_map (
        .i_cnt       (w_cnt_nxt),
        .i_transpose (w_tr_nxt),
        .o_sel_c     (w_sel_map)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef TRANSPOSE_EN
            r_transpose <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= (w_state_nxt == RUN) ? w_sel_map : '0;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
`ifdef TRANSPOSE_EN
            r_transpose <= w_tr_nxt;
`endif
        end
    end

    assign sel       = r_sel;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_matrix_element_sequencer.sv
// Scoreboard bench for matrix_element_sequencer with a behavioural 4x4 mux model.
// Build with TRANSPOSE_EN defined to also exercise column-major scans.
module tb_matrix_element_sequencer;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] i;
        logic       l;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
`ifdef TRANSPOSE_EN
    logic       transpose;
`endif
    logic [3:0] sel;
    logic [7:0] elem_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_idx;
    logic       out_last;
    logic       busy;
    logic       done;

    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    exp_t sb[$];

    logic [7:0] rm_tab [16] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h22, 8'h23, 8'h24,
                                8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44};
    logic [7:0] tr_tab [16] = '{8'h11, 8'h21, 8'h31, 8'h41, 8'h12, 8'h22, 8'h32, 8'h42,
                                8'h13, 8'h23, 8'h33, 8'h43, 8'h14, 8'h24, 8'h34, 8'h44};

    matrix_element_sequencer #(.ELEM_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
`ifdef TRANSPOSE_EN
        .transpose (transpose),
`endif
        .sel       (sel),
        .elem_in   (elem_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mux model: a_rc = 0x{r}{c}, row = sel[1:0], column = sel[3:2]
    always_comb elem_in = {4'(sel[1:0]) + 4'd1, 4'(sel[3:2]) + 4'd1};

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_scan(input int n, input bit tr);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.d = tr ? tr_tab[k] : rm_tab[k];
            e.i = 4'(k);
            e.l = (k == 15);
            sb.push_back(e);
        end
    endtask

    // Starts a scan in the current cycle (cycle 0) and runs until done or a bound
    task automatic run_scan(input int stall_lo, input int stall_hi, input int st_a,
                            input int st_b, input int exp_done, input string name);
        cyc       = 0;
        start     = 1'b1;
        out_ready = 1'b1;
        while (cyc < 60) begin
            tick();
            start = (cyc == st_a) || (cyc == st_b);
`ifdef TRANSPOSE_EN
            transpose = 1'b0;
`endif
            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            if (cyc == 1) check({name, "_busy_run"}, int'(busy), 1);
            if (done) break;
        end
        check({name, "_done_cycle"}, cyc, exp_done);
        check({name, "_busy_at_done"}, int'(busy), 0);
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    // Monitor: pops expected elements on each handshake and checks stall stability
    initial begin
        exp_t       e;
        bit         prev_stall = 1'b0;
        logic [7:0] pd = '0;
        logic [3:0] ps = '0;
        logic [3:0] pi = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && out_valid) begin
                    check("stall_data_held", int'(out_data), int'(pd));
                    check("stall_idx_held", int'(out_idx), int'(pi));
                    check("stall_sel_held", int'(sel), int'(ps));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_elem", int'(out_data), -1);
                    end else begin
                        e = sb.pop_front();
                        check("elem_data", int'(out_data), int'(e.d));
                        check("elem_idx", int'(out_idx), int'(e.i));
                        check("elem_last", int'(out_last), int'(e.l));
                    end
                end
                prev_stall = out_valid && !out_ready;
                pd = out_data;
                ps = sel;
                pi = out_idx;
            end
        end
    end

    initial begin
        bit seen;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
`ifdef TRANSPOSE_EN
        transpose = 1'b0;
`endif
        repeat (3) tick();
        check("reset_outputs", int'({sel, out_valid, out_data, out_idx, out_last, busy, done}), 0);
        reset = 1'b0;
        tick();

        // Full row-major scan without backpressure
        push_scan(16, 1'b0);
        run_scan(-1, -1, -1, -1, 18, "basic");
        tick();
        check("done_one_cycle", int'(done), 0);
        check("basic_all_consumed", sb.size(), 0);

        // Backpressure in cycles 5..7 delays done by three cycles
        push_scan(16, 1'b0);
        run_scan(5, 7, -1, -1, 21, "stall");
        check("stall_all_consumed", sb.size(), 0);
        repeat (2) tick();

        // Abort in cycle 8: element 0x23 is still handed off that cycle
        push_scan(7, 1'b0);
        cyc   = 0;
        start = 1'b1;
        while (cyc < 8) begin
            tick();
            start = 1'b0;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        seen = 1'b0;
        repeat (5) begin
            if (done) seen = 1'b1;
            tick();
        end
        check("abort_no_done", int'(seen), 0);
        check("abort_consumed", sb.size(), 0);
        push_scan(16, 1'b0);
        run_scan(-1, -1, -1, -1, 18, "after_abort");

        // Starts during the scan are ignored; start in the done cycle chains a new scan
        repeat (2) tick();
        push_scan(16, 1'b0);
        run_scan(-1, -1, 3, 10, 18, "ignore_start");
        check("ignore_start_count", sb.size(), 0);
        push_scan(16, 1'b0);
        run_scan(-1, -1, -1, -1, 18, "back_to_back");
        check("back_to_back_consumed", sb.size(), 0);
        repeat (2) tick();

        // Reset asserted mid-scan in cycle 6
        push_scan(4, 1'b0);
        cyc   = 0;
        start = 1'b1;
        while (cyc < 6) begin
            tick();
            start = 1'b0;
        end
        reset = 1'b1;
        tick();
        check("midscan_reset_outputs",
              int'({sel, out_valid, out_data, out_idx, out_last, busy, done}), 0);
        reset = 1'b0;
        check("midscan_reset_consumed", sb.size(), 0);
        sb.delete();
        tick();

`ifdef TRANSPOSE_EN
        // Column-major scan; transpose is only asserted in the start cycle
        push_scan(16, 1'b1);
        transpose = 1'b1;
        run_scan(-1, -1, -1, -1, 18, "transpose");
        check("transpose_consumed", sb.size(), 0);
        repeat (2) tick();
`endif

        // Row-major again after everything else
        push_scan(16, 1'b0);
        run_scan(-1, -1, -1, -1, 18, "final");
        check("final_consumed", sb.size(), 0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
